// File: rtl/dsp_seq_pkg.sv
// Shared types for the DSP MAC sequencer: slice opmode words, FSM states
// and the per-cycle tag that travels alongside operands through the slice.
package dsp_seq_pkg;

  // Opmode words. Bits 7..4 stay 0: no pre-adder, carry-in 0, post-adder adds.
  localparam logic [7:0] OPM_FIRST = 8'h01;  // X=M, Z=0 : start a new sum
  localparam logic [7:0] OPM_ACC   = 8'h09;  // X=M, Z=P : accumulate
  localparam logic [7:0] OPM_HOLD  = 8'h08;  // X=0, Z=P : keep P
  localparam logic [7:0] OPM_IDLE  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FEED  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_ZERO  = 2'd3
  } state_t;

  // One tag per cycle: v marks a real operand pair, first/last mark the
  // boundaries of the job.
  typedef struct packed {
    logic v;
    logic first;
    logic last;
  } tag_t;

  localparam tag_t TAG_NONE = '0;

endpackage

// File: rtl/dsp_tag_pipe.sv
// Fixed-depth tag delay line that mirrors the slice pipeline. Stage k holds
// the tag pushed k cycles ago; stage LAG steers the opmode, stage DEPTH
// marks the cycle in which that operand's product is visible on P.
module dsp_tag_pipe
  import dsp_seq_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int LAG   = 1
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_lag,
  output tag_t tag_out
);

  tag_t stage_q [1:DEPTH];
  tag_t stage_d [1:DEPTH];

  // Shift by one stage every cycle; bubbles enter as empty tags.
  always_comb begin
    stage_d[1] = tag_in;
    for (int k = 2; k <= DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  // Tag storage, cleared by reset so an aborted job leaves nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= TAG_NONE;
      end
    end else begin
      for (int k = 1; k <= DEPTH; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign tag_lag = stage_q[LAG];
  assign tag_out = stage_q[DEPTH];

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives a DSP slice as an N-tap unsigned multiply-accumulate engine.
// Handshake: an operand pair transfers in a cycle where s_valid and s_ready
// are both 1; s_ready does not depend on s_valid, and s_valid may drop at
// any time, which simply inserts a HOLD bubble into the slice.
module dsp_mac_sequencer
  import dsp_seq_pkg::*;
#(
  parameter int LEN_W      = 10,
  parameter int OPMODE_LAG = 1,
  parameter int P_LAT      = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [17:0]      s_a,
  input  logic [17:0]      s_b,
  output logic [17:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [7:0]       dsp_opmode,
  output logic             dsp_ce,
  input  logic [47:0]      dsp_p,
  output logic             busy,
  output logic             res_valid,
  output logic [47:0]      res_data
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             first_q, first_d;
  logic [17:0]      a_q, a_d;
  logic [17:0]      b_q, b_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [47:0]      res_data_q, res_data_d;
  logic             ce_q;
  logic             accept;
  tag_t             tag_in, tag_lag, tag_out;
  logic [1:0]       unused_tag_bits;

  dsp_tag_pipe #(
    .DEPTH (P_LAT),
    .LAG   (OPMODE_LAG)
  ) u_tag_pipe (
    .clk     (clk),
    .rst     (rst),
    .tag_in  (tag_in),
    .tag_lag (tag_lag),
    .tag_out (tag_out)
  );

  assign unused_tag_bits = {tag_lag.last, tag_out.first};

  assign s_ready = (state_q == ST_FEED) && (rem_q != '0);
  assign accept  = s_ready && s_valid;

  // Next-state, operand capture, tag generation and result capture.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    first_d     = first_q;
    a_d         = a_q;
    b_d         = b_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    tag_in      = TAG_NONE;
    unique case (state_q)
      // ZERO is the result cycle of an empty job and is not busy, so it
      // accepts a new start exactly like IDLE.
      ST_IDLE, ST_ZERO: begin
        state_d = ST_IDLE;
        if (start) begin
          if (len != '0) begin
            rem_d   = len;
            first_d = 1'b1;
            busy_d  = 1'b1;
            state_d = ST_FEED;
          end else begin
            res_valid_d = 1'b1;
            res_data_d  = '0;
            state_d     = ST_ZERO;
          end
        end
      end
      ST_FEED: begin
        if (accept) begin
          a_d          = s_a;
          b_d          = s_b;
          rem_d        = rem_q - LEN_W'(1);
          first_d      = 1'b0;
          tag_in.v     = 1'b1;
          tag_in.first = first_q;
          tag_in.last  = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // The last product is in P exactly when its tag leaves the line.
        if (tag_out.v && tag_out.last) begin
          res_data_d  = dsp_p;
          res_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Opmode follows the tag that is OPMODE_LAG cycles old so it meets its
  // product at the slice post-adder; bubbles hold P during a job.
  always_comb begin
    dsp_opmode = OPM_IDLE;
    if (tag_lag.v) begin
      dsp_opmode = tag_lag.first ? OPM_FIRST : OPM_ACC;
    end else if (busy_q) begin
      dsp_opmode = OPM_HOLD;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      first_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      ce_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      first_q     <= first_d;
      a_q         <= a_d;
      b_q         <= b_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      ce_q        <= 1'b1;
    end
  end

  assign dsp_a     = a_q;
  assign dsp_b     = b_q;
  assign dsp_ce    = ce_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer with a behavioural DSP slice model alongside.
module tb_dsp_mac_sequencer;

  localparam int W     = 48;
  localparam int LEN_W = 10;
  localparam int HIST  = 8192;

  logic             clk;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             s_valid;
  logic             s_ready;
  logic [17:0]      s_a, s_b;
  logic [17:0]      dsp_a, dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_ce;
  logic [47:0]      dsp_p;
  logic             busy;
  logic             res_valid;
  logic [47:0]      res_data;

  dsp_mac_sequencer #(
    .LEN_W      (LEN_W),
    .OPMODE_LAG (1),
    .P_LAT      (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_a        (s_a),
    .s_b        (s_b),
    .dsp_a      (dsp_a),
    .dsp_b      (dsp_b),
    .dsp_opmode (dsp_opmode),
    .dsp_ce     (dsp_ce),
    .dsp_p      (dsp_p),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_data   (res_data)
  );

  // ---------------- slice model ----------------
  // The sequencer's operand register acts as the A1/B1 stage; the slice then
  // has the M register, the opmode register and the P register.
  logic [47:0] m_r  = '0;
  logic [7:0]  op_r = '0;
  logic [47:0] p_r  = '0;
  assign dsp_p = p_r;

  always @(posedge clk) begin
    if (dsp_ce) begin
      m_r  <= {30'd0, dsp_a} * {30'd0, dsp_b};
      op_r <= dsp_opmode;
      case (op_r)
        8'h01:   p_r <= m_r;
        8'h09:   p_r <= p_r + m_r;
        8'h08:   p_r <= p_r;
        default: p_r <= '0;
      endcase
    end
  end

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d required < 50000", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  logic [7:0]   opm_hist [0:HIST-1];
  int           res_cnt = 0;
  logic         sready_seen = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (cyc < HIST) opm_hist[cyc] = dsp_opmode;
    if (!rst) begin
      if (s_ready) sready_seen = 1'b1;
      if (res_valid) begin
        res_cnt++;
        if (exp_q.size() == 0) begin
          check_val("unexpected_res_valid", res_valid, 0);
        end else begin
          logic [W-1:0] e;
          int ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check_val("res_data", res_data, e);
          check_val("res_cycle", cyc, ec);
          check_val("busy_at_res", busy, 0);
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [17:0] op_a [0:1023];
  logic [17:0] op_b [0:1023];

  function automatic logic [W-1:0] ref_sum(input int n);
    logic [W-1:0] s;
    longint unsigned p;
    s = '0;
    for (int i = 0; i < n; i++) begin
      p = longint'(op_a[i]) * longint'(op_b[i]);
      s = s + W'(p);
    end
    return s;
  endfunction

  // ---------------- driver tasks ----------------
  // All tasks begin and end at posedge+1.
  task automatic start_job(input int l);
    int sc;
    start = 1'b1;
    len   = LEN_W'(l);
    sc    = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    if (l == 0) begin
      exp_q.push_back('0);
      exp_cyc_q.push_back(sc + 1);
    end
  endtask

  task automatic send_pair(input logic [17:0] a, input logic [17:0] b, output int acc);
    bit done;
    done    = 1'b0;
    acc     = -1;
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (s_ready) begin
        acc  = cyc;
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    if (!done) check_val("accept_timeout", 0, 1);
  endtask

  task automatic feed_job(input int l, input int max_gap);
    int acc;
    for (int i = 0; i < l; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        @(posedge clk); #1;
      end
      send_pair(op_a[i], op_b[i], acc);
    end
    exp_q.push_back(ref_sum(l));
    exp_cyc_q.push_back(acc + 4);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64 && exp_q.size() != 0; i++) @(negedge clk);
    check_val("result_pending", exp_q.size(), 0);
    exp_q.delete();
    exp_cyc_q.delete();
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, a1, a2, rc, l;
    rst = 1'b0; start = 1'b0; len = '0; s_valid = 1'b0; s_a = '0; s_b = '0;
    #1 rst = 1'b1;
    #1;
    check_val("reset_outs", {s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, busy, res_valid, res_data}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1 check_val("ce_before_edge", dsp_ce, 0);
    @(posedge clk); #1;
    check_val("ce_after_edge", dsp_ce, 1);

    // len=3 back-to-back: 1*4+2*5+3*6 = 32, result 4 cycles after last accept
    op_a[0] = 1; op_b[0] = 4; op_a[1] = 2; op_b[1] = 5; op_a[2] = 3; op_b[2] = 6;
    check_val("sum3_model", ref_sum(3), 32);
    start_job(3);
    feed_job(3, 0);
    wait_idle();

    // same job with two bubble cycles after the first tap
    start_job(3);
    send_pair(1, 4, a0);
    repeat (2) begin @(posedge clk); #1; end
    send_pair(2, 5, a1);
    send_pair(3, 6, a2);
    exp_q.push_back(48'd32);
    exp_cyc_q.push_back(a0 + 8);
    wait_idle();
    check_val("bubble_accept_gap", a1 - a0, 3);
    check_val("opm_first", opm_hist[a0 + 1], 8'h01);
    check_val("opm_bubble0", opm_hist[a0 + 2], 8'h08);
    check_val("opm_bubble1", opm_hist[a0 + 3], 8'h08);
    check_val("opm_acc1", opm_hist[a0 + 4], 8'h09);
    check_val("opm_acc2", opm_hist[a0 + 5], 8'h09);

    // len=1 with maximum operands
    start_job(1);
    send_pair(18'h3FFFF, 18'h3FFFF, a0);
    exp_q.push_back(48'h0000FFFF80001);
    exp_cyc_q.push_back(a0 + 4);
    wait_idle();

    // len=0: immediate zero result, no operand handshake
    sready_seen = 1'b0;
    start_job(0);
    wait_idle();
    check_val("zero_no_sready", sready_seen, 0);

    // second start issued in the res_valid cycle of the first job
    op_a[0] = 5; op_b[0] = 6; op_a[1] = 7; op_b[1] = 8;
    start_job(2);
    feed_job(2, 0);
    rc = 0;
    for (int i = 0; i < 32 && rc == 0; i++) begin
      @(negedge clk);
      if (res_valid) rc = 1;
    end
    check_val("first_res_seen", rc, 1);
    start = 1'b1; len = LEN_W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("second_start_busy", busy, 1);
    op_a[0] = 2; op_b[0] = 2; op_a[1] = 3; op_b[1] = 3;
    feed_job(2, 0);
    wait_idle();

    // start while busy is ignored
    start_job(2);
    send_pair(4, 4, a0);
    start = 1'b1; len = LEN_W'(5);
    @(posedge clk); #1;
    start = 1'b0;
    send_pair(5, 5, a1);
    exp_q.push_back(48'd41);
    exp_cyc_q.push_back(a1 + 4);
    wait_idle();
    repeat (6) begin @(posedge clk); #1; end
    check_val("ignored_start_idle", {busy, s_ready}, 0);

    // reset in the middle of FEED
    start_job(4);
    send_pair(9, 9, a0);
    send_pair(8, 8, a0);
    rc = res_cnt;
    rst = 1'b1;
    #1 check_val("rst_mid_outs", {s_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce, busy, res_valid, res_data}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    check_val("rst_no_res", res_cnt, rc);
    start_job(1);
    send_pair(7, 7, a0);
    exp_q.push_back(48'd49);
    exp_cyc_q.push_back(a0 + 4);
    wait_idle();

    // randomized jobs with random bubbles
    for (int j = 0; j < 24; j++) begin
      l = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
      for (int i = 0; i < l; i++) begin
        op_a[i] = 18'($urandom_range(0, 18'h3FFFF));
        op_b[i] = 18'($urandom_range(0, 18'h3FFFF));
      end
      start_job(l);
      if (l != 0) feed_job(l, 2);
      wait_idle();
    end

    // maximum job length with maximum operands
    for (int i = 0; i < 1023; i++) begin
      op_a[i] = 18'h3FFFF;
      op_b[i] = 18'h3FFFF;
    end
    start_job(1023);
    feed_job(1023, 0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
